// File: rtl/pf_vf_mux_pkg.sv
// Shared PF/VF tag types for the PF/VF mux datapaths.
package pf_vf_mux_pkg;

  localparam int PF_WIDTH = 3;
  localparam int VF_WIDTH = 11;

  typedef struct packed {
    logic [PF_WIDTH-1:0] pf;
    logic [VF_WIDTH-1:0] vf;
    logic                vf_active;
  } t_pfvf_tag;

  function automatic t_pfvf_tag make_tag(input logic [PF_WIDTH-1:0] pf,
                                         input logic [VF_WIDTH-1:0] vf,
                                         input logic                va);
    t_pfvf_tag t;
    t.pf        = pf;
    t.vf        = vf;
    t.vf_active = va;
    return t;
  endfunction

endpackage

// File: rtl/pfvf_umux_skid.sv
// Two-entry skid buffer with registered output for the upstream PF/VF mux.
module pfvf_umux_skid
  import pf_vf_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int PID_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  t_pfvf_tag             push_tag,
  input  logic [PID_W-1:0]      push_pid,
  output logic                  full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output t_pfvf_tag             out_tag,
  output logic [PID_W-1:0]      out_pid
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    t_pfvf_tag             tag;
    logic [PID_W-1:0]      pid;
  } t_entry;

  t_entry     main_q, skid_q, in_entry;
  logic [1:0] count_q;
  logic       pop;

  assign in_entry  = '{data: push_data, last: push_last, tag: push_tag, pid: push_pid};
  assign out_valid = (count_q != 2'd0);
  assign full      = (count_q == 2'd2);
  assign pop       = out_valid & out_ready;

  // main_q always holds the oldest entry; skid_q only fills when main stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q  <= '0;
      skid_q  <= '0;
      count_q <= 2'd0;
    end else begin
      if (pop && count_q == 2'd2)
        main_q <= skid_q;
      else if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop)))
        main_q <= in_entry;
      if (push && count_q == 2'd1 && !pop)
        skid_q <= in_entry;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_data = main_q.data;
  assign out_last = main_q.last;
  assign out_tag  = main_q.tag;
  assign out_pid  = main_q.pid;

endmodule

// File: rtl/pfvf_upstream_mux.sv
// Upstream PF/VF mux: packet-level round-robin merge of port streams with PF/VF stamping.
// Optional per-port packet counters under PFVF_UMUX_STATS_EN.
module pfvf_upstream_mux
  import pf_vf_mux_pkg::*;
#(
  parameter int                  NUM_PORT              = 4,
  parameter int                  DATA_WIDTH            = 512,
  parameter logic [PF_WIDTH-1:0] PORT_PF [NUM_PORT]    = '{0, 0, 0, 0},
  parameter logic [VF_WIDTH-1:0] PORT_VF [NUM_PORT]    = '{0, 1, 2, 0},
  parameter logic                PORT_VA [NUM_PORT]    = '{1, 1, 1, 0},
  parameter logic [NUM_PORT-1:0] PORT_PASSTHRU         = 4'b1000,
  localparam int                 PID_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORT-1:0]            in_tvalid,
  output logic [NUM_PORT-1:0]            in_tready,
  input  logic [NUM_PORT*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_PORT-1:0]            in_tlast,
  input  logic [NUM_PORT*PF_WIDTH-1:0]   in_pf,
  input  logic [NUM_PORT*VF_WIDTH-1:0]   in_vf,
  input  logic [NUM_PORT-1:0]            in_vf_active,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic [DATA_WIDTH-1:0]          out_tdata,
  output logic                           out_tlast,
  output logic [PF_WIDTH-1:0]            out_pf,
  output logic [VF_WIDTH-1:0]            out_vf,
  output logic                           out_vf_active,
  output logic [PID_W-1:0]               out_src_pid
`ifdef PFVF_UMUX_STATS_EN
 ,input  logic                           stats_clr,
  output logic [NUM_PORT*32-1:0]         pkt_cnt
`endif
);

  typedef enum logic {S_IDLE, S_LOCKED} t_state;

  t_state                state_q, state_d;
  logic [PID_W-1:0]      ptr_q, ptr_d, lock_pid_q, lock_pid_d;
  t_pfvf_tag             held_tag_q, held_tag_d, cur_tag, out_tag;
  logic                  rdy_en_q;
  logic                  rr_vld, grant_vld, can_take, accept, acc_last, skid_full;
  logic [PID_W-1:0]      rr_pid, cand, grant;
  logic [DATA_WIDTH-1:0] data_a   [NUM_PORT];
  t_pfvf_tag             port_tag [NUM_PORT];

  for (genvar g = 0; g < NUM_PORT; g++) begin : g_port
    assign data_a[g]   = in_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign port_tag[g] = PORT_PASSTHRU[g]
                       ? make_tag(in_pf[g*PF_WIDTH +: PF_WIDTH], in_vf[g*VF_WIDTH +: VF_WIDTH],
                                  in_vf_active[g])
                       : make_tag(PORT_PF[g], PORT_VF[g], PORT_VA[g]);
  end

  always_comb begin
    rr_vld = 1'b0;
    rr_pid = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_PORT; k++) begin
      cand = PID_W'((32'(ptr_q) + k) % NUM_PORT);
      if (!rr_vld && in_tvalid[cand]) begin
        rr_vld = 1'b1;
        rr_pid = cand;
      end
    end
  end

  // in_tready depends only on state/skid occupancy, never on out_tready.
  always_comb begin
    grant_vld = (state_q == S_LOCKED) | rr_vld;
    grant     = (state_q == S_LOCKED) ? lock_pid_q : rr_pid;
    can_take  = grant_vld & ~skid_full & rdy_en_q;
    in_tready = '0;
    if (can_take) in_tready[grant] = 1'b1;
    accept    = can_take & in_tvalid[grant];
    acc_last  = accept & in_tlast[grant];
    cur_tag   = (state_q == S_LOCKED) ? held_tag_q : port_tag[grant];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_pid_d = lock_pid_q;
    held_tag_d = held_tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (acc_last) begin
            ptr_d = grant;
          end else begin
            state_d    = S_LOCKED;
            lock_pid_d = grant;
            held_tag_d = cur_tag;
          end
        end
      end
      S_LOCKED: begin
        if (acc_last) begin
          state_d = S_IDLE;
          ptr_d   = grant;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= PID_W'(NUM_PORT - 1);
      lock_pid_q <= '0;
      held_tag_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_pid_q <= lock_pid_d;
      held_tag_q <= held_tag_d;
      rdy_en_q   <= 1'b1;
    end
  end

  pfvf_umux_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .PID_W      (PID_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (data_a[grant]),
    .push_last (in_tlast[grant]),
    .push_tag  (cur_tag),
    .push_pid  (grant),
    .full      (skid_full),
    .out_valid (out_tvalid),
    .out_ready (out_tready),
    .out_data  (out_tdata),
    .out_last  (out_tlast),
    .out_tag   (out_tag),
    .out_pid   (out_src_pid)
  );

  assign out_pf        = out_tag.pf;
  assign out_vf        = out_tag.vf;
  assign out_vf_active = out_tag.vf_active;

`ifdef PFVF_UMUX_STATS_EN
  logic [31:0] cnt_q [NUM_PORT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_PORT; k++) cnt_q[k] <= '0;
    end else if (stats_clr) begin
      for (int unsigned k = 0; k < NUM_PORT; k++) cnt_q[k] <= '0;
    end else if (acc_last && cnt_q[grant] != '1) begin
      cnt_q[grant] <= cnt_q[grant] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORT; g++) begin : g_cnt
    assign pkt_cnt[g*32 +: 32] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_pfvf_upstream_mux.sv
// Scoreboard bench for pfvf_upstream_mux (default 4-port map; stats checks with PFVF_UMUX_STATS_EN).
module tb_pfvf_upstream_mux;

  localparam int NP = 4;
  localparam int DW = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     in_tvalid, in_tready, in_tlast, in_vf_active;
  logic [NP*DW-1:0]  in_tdata;
  logic [NP*3-1:0]   in_pf;
  logic [NP*11-1:0]  in_vf;
  logic              out_tvalid, out_tready, out_tlast, out_vf_active;
  logic [DW-1:0]     out_tdata;
  logic [2:0]        out_pf;
  logic [10:0]       out_vf;
  logic [1:0]        out_src_pid;
`ifdef PFVF_UMUX_STATS_EN
  logic              stats_clr;
  logic [NP*32-1:0]  pkt_cnt;
`endif

  always #5 clk = ~clk;

  pfvf_upstream_mux #(
    .NUM_PORT   (NP),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_tvalid     (in_tvalid),
    .in_tready     (in_tready),
    .in_tdata      (in_tdata),
    .in_tlast      (in_tlast),
    .in_pf         (in_pf),
    .in_vf         (in_vf),
    .in_vf_active  (in_vf_active),
    .out_tvalid    (out_tvalid),
    .out_tready    (out_tready),
    .out_tdata     (out_tdata),
    .out_tlast     (out_tlast),
    .out_pf        (out_pf),
    .out_vf        (out_vf),
    .out_vf_active (out_vf_active),
    .out_src_pid   (out_src_pid)
`ifdef PFVF_UMUX_STATS_EN
   ,.stats_clr     (stats_clr),
    .pkt_cnt       (pkt_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [2:0]    pf;
    logic [10:0]   vf;
    logic          va;
    logic [1:0]    pid;
  } beat_t;

  beat_t         port_q [NP][$];
  beat_t         exp_q[$];
  beat_t         mon_e;
  logic [DW-1:0] d_a  [NP];
  logic [2:0]    pf_a [NP];
  logic [10:0]   vf_a [NP];
  logic [NP-1:0] vld, last_a, va_a, acc;
  int unsigned   n_checks = 0, n_pass = 0;
  int            cyc = 0;
  int            pop_cyc[$];
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_d;

  assign in_tvalid    = vld;
  assign in_tlast     = last_a;
  assign in_vf_active = va_a;
  assign in_tdata     = {d_a[3], d_a[2], d_a[1], d_a[0]};
  assign in_pf        = {pf_a[3], pf_a[2], pf_a[1], pf_a[0]};
  assign in_vf        = {vf_a[3], vf_a[2], vf_a[1], vf_a[0]};

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Queue a packet on port p and its expected host-side beats.
  function automatic void send_pkt(input int p, input int len, input logic [2:0] pf,
                                   input logic [10:0] vf, input logic va, input logic [10:0] vf_late);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
      b.last = (i == len - 1);
      b.pf   = pf;
      b.vf   = (i == 0) ? vf : vf_late;
      b.va   = va;
      b.pid  = 2'(p);
      port_q[p].push_back(b);
      e = b;
      if (p == 3) begin
        e.pf = pf; e.vf = vf; e.va = va;
      end else begin
        e.pf = 3'd0; e.vf = 11'(p); e.va = 1'b1;
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      cycles(1);
      i++;
    end
    check("drain_left", exp_q.size(), 0);
    cycles(1);
  endtask

  // Source driver: each port presents its queue head until accepted.
  initial begin
    vld = '0; last_a = '0; va_a = '0;
    for (int p = 0; p < NP; p++) begin
      d_a[p] = '0; pf_a[p] = '0; vf_a[p] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p] && port_q[p].size() > 0) void'(port_q[p].pop_front());
        if (port_q[p].size() > 0) begin
          vld[p]    = 1'b1;
          d_a[p]    = port_q[p][0].data;
          last_a[p] = port_q[p][0].last;
          pf_a[p]   = port_q[p][0].pf;
          vf_a[p]   = port_q[p][0].vf;
          va_a[p]   = port_q[p][0].va;
        end else begin
          vld[p] = 1'b0;
        end
      end
    end
  end

  // Monitor: handshakes sampled at the falling edge, ahead of the transferring rising edge.
  initial begin
    acc = '0;
    forever begin
      @(negedge clk);
      cyc++;
      acc = vld & in_tready;
      if (rst_n && hold_pend) begin
        check("hold_valid", out_tvalid, 1);
        check("hold_data", out_tdata, hold_d);
      end
      if (rst_n && out_tvalid && out_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", out_tvalid, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("beat_data", out_tdata, mon_e.data);
          check("beat_meta", {out_src_pid, out_vf_active, out_vf, out_pf, out_tlast},
                {mon_e.pid, mon_e.va, mon_e.vf, mon_e.pf, mon_e.last});
          pop_cyc.push_back(cyc);
        end
      end
      hold_pend = rst_n & out_tvalid & ~out_tready;
      hold_d    = out_tdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    out_tready = 1'b1;
`ifdef PFVF_UMUX_STATS_EN
    stats_clr  = 1'b0;
`endif
    // 1: all ports with single-beat packets, two rounds
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        if (p == 3) send_pkt(3, 1, 3'd4, 11'd9, 1'b1, 11'd9);
        else        send_pkt(p, 1, 3'd7, 11'h7ff, 1'b0, 11'h7ff);
    cycles(3);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_in_tready", in_tready, 0);
    check("rst_out_tdata", out_tdata, 0);
    check("rst_out_meta", {out_src_pid, out_vf_active, out_vf, out_pf, out_tlast}, 0);
    rst_n = 1'b1;
    #1;
    check("first_cycle_tready", in_tready, 0);
    pop_cyc.delete();
    drain();
    check("t1_span", pop_cyc[7] - pop_cyc[0], 7);

    // 2: 4-beat packet on port 1, port 2 requests mid-packet
    pop_cyc.delete();
    send_pkt(1, 4, 3'd5, 11'h3aa, 1'b0, 11'h155);
    cycles(2);
    send_pkt(2, 2, 3'd6, 11'h111, 1'b0, 11'h222);
    drain();
    check("t2_span", pop_cyc[5] - pop_cyc[0], 5);

    // 3: pass-through port changes in_vf mid-packet
    send_pkt(3, 3, 3'd2, 11'd5, 1'b1, 11'd7);
    drain();

    // 4: back-pressure 1,0,0,1 while streaming
    send_pkt(0, 8, 3'd1, 11'd3, 1'b0, 11'd4);
    cycles(3);
    out_tready = 1'b0;
    cycles(1);
    check("t4_tready_full", in_tready[0], 0);
    check("t4_out_tvalid", out_tvalid, 1);
    cycles(1);
    out_tready = 1'b1;
    drain();

    // 5: async reset mid-packet, port 0 wins first afterwards
    send_pkt(0, 6, 3'd1, 11'd3, 1'b0, 11'd3);
    cycles(4);
    check("t5_pre_tvalid", out_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_tvalid", out_tvalid, 0);
    check("t5_async_tready", in_tready, 0);
    exp_q.delete();
    for (int p = 0; p < NP; p++) port_q[p].delete();
    cycles(1);
    send_pkt(0, 1, 3'd7, 11'h7ff, 1'b0, 11'h7ff);
    send_pkt(1, 1, 3'd7, 11'h7ff, 1'b0, 11'h7ff);
    cycles(1);
    rst_n = 1'b1;
    #1;
    check("t5_first_cycle_tready", in_tready, 0);
    drain();

`ifdef PFVF_UMUX_STATS_EN
    // 6: per-port packet counters and clear-over-increment
    for (int i = 0; i < 3; i++) send_pkt(2, 1, 3'd0, 11'd0, 1'b0, 11'd0);
    drain();
    check("cnt_port2", pkt_cnt[95:64], 3);
    check("cnt_port0", pkt_cnt[31:0], 1);
    check("cnt_port1", pkt_cnt[63:32], 1);
    send_pkt(2, 1, 3'd0, 11'd0, 1'b0, 11'd0);
    stats_clr = 1'b1;
    cycles(2);
    stats_clr = 1'b0;
    cycles(1);
    check("cnt_cleared", pkt_cnt, 0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
